// File: rtl/mem_arbiter_pkg.sv
// Shared memory-port definitions: access width codes and the response FSM states
// used by the fetch/data arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_IF   = 2'b01,
    RESP_D    = 2'b10
  } resp_state_e;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port has been denied while
// requesting; at_max_o tells the arbiter to let fetch win.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic if_gnt_i,
  output logic at_max_o
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_VAL = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // A grant or an idle fetch port restarts the starvation window.
  always_comb begin
    cnt_d = '0;
    if (if_req_i && !if_gnt_i) begin
      cnt_d = (cnt_q == MAX_VAL) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with
// data priority, bounded fetch starvation and one-cycle read responses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_store,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_width,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_pc,
  output logic [31:0] m_addr,
  output logic        m_store,
  output logic        m_unsigned,
  output logic [1:0]  m_width,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  logic        starveMax;
  logic        ifWins;
  logic [31:0] lastPc_q, lastPc_d;
  resp_state_e respState_q, respState_d;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .if_req_i (if_req),
    .if_gnt_i (if_gnt),
    .at_max_o (starveMax)
  );

  // Data wins by default; a starved fetch overrides it for one grant.
  always_comb begin
    ifWins = if_req && (!d_req || starveMax);
    if_gnt = !rst && ifWins;
    d_gnt  = !rst && d_req && !ifWins;
  end

  always_comb begin
    m_pc       = '0;
    m_addr     = '0;
    m_store    = 1'b0;
    m_unsigned = 1'b0;
    m_width    = '0;
    m_wdata    = '0;
    if (if_gnt) begin
      m_pc    = if_addr;
      m_addr  = if_addr;
      m_width = MEM_WORD;
    end else if (d_gnt) begin
      m_pc       = lastPc_q;
      m_addr     = d_addr;
      m_store    = d_store;
      m_unsigned = d_unsigned;
      m_width    = d_width;
      m_wdata    = d_wdata;
    end
  end

  always_comb begin
    lastPc_d = if_gnt ? if_addr : lastPc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastPc_q <= '0;
    end else begin
      lastPc_q <= lastPc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      respState_q <= RESP_NONE;
    end else begin
      respState_q <= respState_d;
    end
  end

  // Stores complete at grant, so only fetches and loads await read data.
  always_comb begin
    respState_d = RESP_NONE;
    if (if_gnt) begin
      respState_d = RESP_IF;
    end else if (d_gnt && !d_store) begin
      respState_d = RESP_D;
    end
  end

  // Outputs are masked by rst so a response in flight at reset is dropped.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (!rst) begin
      case (respState_q)
        RESP_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = m_rdata;
        end
        RESP_D: begin
          d_rvalid = 1'b1;
          d_rdata  = m_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: a transaction-level model
// predicts grants and memory-port values, and a scoreboard checks read responses.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_store, d_unsigned, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_width;
  logic [31:0] m_pc, m_addr, m_wdata, m_rdata;
  logic        m_store, m_unsigned;
  logic [1:0]  m_width;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_store(d_store), .d_addr(d_addr), .d_width(d_width),
    .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_pc(m_pc), .m_addr(m_addr), .m_store(m_store), .m_unsigned(m_unsigned),
    .m_width(m_width), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isIf;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t expQ[$];
  resp_t monResp;
  int    passCount = 0;
  int    checkCount = 0;
  int    cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Memory contents are a fixed function of address; data returns a cycle late.
  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  logic [31:0] memAddr = '0;
  always @(posedge clk) memAddr <= m_addr;
  assign m_rdata = memData(memAddr);

  bit          rstM, ifPend, dPend, dSt, dUn;
  logic [31:0] ifA, dA, dW, lastPc;
  logic [1:0]  dWd;
  int          starve;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
  endtask

  task automatic issueFetch(input logic [31:0] a);
    if (!ifPend) begin
      ifPend = 1'b1;
      ifA    = a;
    end
  endtask

  task automatic issueData(input bit st, input logic [31:0] a, input logic [1:0] wd,
                           input bit un, input logic [31:0] wdat);
    if (!dPend) begin
      dPend = 1'b1;
      dSt = st; dA = a; dWd = wd; dUn = un; dW = wdat;
    end
  endtask

  // One clock: drive, compare grant/memory port at negedge, advance the model.
  task automatic applyStimulus();
    bit ifWin, dWin;
    if (rstM) expQ.delete();
    rst = rstM;
    if_req = ifPend; if_addr = ifA;
    d_req = dPend; d_store = dSt; d_addr = dA; d_width = dWd;
    d_unsigned = dUn; d_wdata = dW;
    @(negedge clk);
    ifWin = !rstM && ifPend && (!dPend || starve == STARVE_MAX);
    dWin  = !rstM && dPend && !ifWin;
    checkOutput("if_gnt", {31'b0, if_gnt}, {31'b0, ifWin});
    checkOutput("d_gnt", {31'b0, d_gnt}, {31'b0, dWin});
    checkOutput("m_pc", m_pc, ifWin ? ifA : (dWin ? lastPc : 32'h0));
    checkOutput("m_addr", m_addr, ifWin ? ifA : (dWin ? dA : 32'h0));
    checkOutput("m_store", {31'b0, m_store}, {31'b0, dWin && dSt});
    checkOutput("m_unsigned", {31'b0, m_unsigned}, {31'b0, dWin && dUn});
    checkOutput("m_width", {30'b0, m_width}, {30'b0, ifWin ? MEM_WORD : (dWin ? dWd : 2'b00)});
    checkOutput("m_wdata", m_wdata, dWin ? dW : 32'h0);
    if (rstM) begin
      starve = 0;
      lastPc = '0;
    end else begin
      starve = (ifWin || !ifPend) ? 0 : ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX);
      if (ifWin) begin
        lastPc = ifA;
        expQ.push_back('{isIf: 1'b1, data: memData(ifA), due: cycle + 1});
        ifPend = 1'b0;
      end
      if (dWin) begin
        if (!dSt) expQ.push_back('{isIf: 1'b0, data: memData(dA), due: cycle + 1});
        dPend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each rvalid must match the oldest outstanding read, on time.
  always @(negedge clk) begin
    if (if_rvalid || d_rvalid) begin
      if (expQ.size() == 0 || expQ[0].due != cycle) begin
        checkOutput("unexpected_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'h0);
      end else begin
        monResp = expQ.pop_front();
        checkOutput("if_rvalid", {31'b0, if_rvalid}, {31'b0, monResp.isIf});
        checkOutput("d_rvalid", {31'b0, d_rvalid}, {31'b0, !monResp.isIf});
        checkOutput("rdata", monResp.isIf ? if_rdata : d_rdata, monResp.data);
        checkOutput("idle_rdata", monResp.isIf ? d_rdata : if_rdata, 32'h0);
      end
    end else begin
      checkOutput("idle_rdata_both", if_rdata | d_rdata, 32'h0);
      if (expQ.size() != 0 && expQ[0].due <= cycle) begin
        monResp = expQ.pop_front();
        checkOutput("missing_rvalid", 32'h0, {31'b0, 1'b1});
      end
    end
  end

  initial begin
    rstM = 1'b1; ifPend = 1'b0; dPend = 1'b0; dSt = 1'b0; dUn = 1'b0;
    ifA = '0; dA = '0; dW = '0; dWd = '0; lastPc = '0; starve = 0;
    repeat (2) applyStimulus();
    rstM = 1'b0;
    applyStimulus();

    $display("[TB] fetch-only read of 0x100");
    issueFetch(32'h100);
    repeat (2) applyStimulus();

    $display("[TB] simultaneous fetch and load");
    issueFetch(32'h200);
    issueData(1'b0, 32'h300, MEM_WORD, 1'b0, 32'h0);
    repeat (3) applyStimulus();

    $display("[TB] continuous data traffic starving fetch");
    issueFetch(32'h400);
    for (int i = 0; i < 8; i++) begin
      issueData(1'b0, 32'h500 + 32'(i * 4), MEM_HALF, i[0], 32'h0);
      applyStimulus();
    end
    applyStimulus();

    $display("[TB] store to 0x8");
    issueData(1'b1, 32'h8, MEM_WORD, 1'b0, 32'h55);
    repeat (2) applyStimulus();

    $display("[TB] reset right after a load grant");
    issueData(1'b0, 32'hC, MEM_WORD, 1'b0, 32'h0);
    applyStimulus();
    rstM = 1'b1;
    applyStimulus();
    rstM = 1'b0;
    issueFetch(32'h100);
    repeat (2) applyStimulus();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) issueFetch($urandom & 32'h0000_FFFC);
      if ($urandom_range(0, 3) != 0)
        issueData($urandom_range(0, 1) == 1, $urandom, 2'($urandom_range(0, 2)),
                  $urandom_range(0, 1) == 1, $urandom);
      rstM = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    rstM = 1'b0;
    repeat (12) applyStimulus();
    ifPend = 1'b0;
    dPend = 1'b0;
    repeat (3) applyStimulus();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, max consecutive cycles the fetch port may be denied while requesting.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req  in  1  instruction-fetch read request.
REQ-005 if_addr  in  32  fetch byte address, word-aligned.
REQ-006 if_gnt  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid  out  1  fetch read data valid.
REQ-008 if_rdata  out  32  fetch read data.
REQ-009 d_req  in  1  data-port request (load or store).
REQ-010 d_store  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_width  in  2  access width code (byte/half/word, shared package encoding).
REQ-013 d_unsigned  in  1  zero-extend load.
REQ-014 d_wdata  in  32  store data, unshifted.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_rvalid  out  1  load data valid.
REQ-017 d_rdata  out  32  load data.
REQ-018 m_pc, m_addr  out  32 each  memory-port pc/address of the accepted request.
REQ-019 m_store, m_unsigned  out  1 each; m_width  out  2; m_wdata  out  32  memory-port controls.
REQ-020 m_rdata  in  32  memory-port read data, valid one cycle after the address is presented.

Function
REQ-021 The block shall accept at most one request per cycle and present it combinationally on the m_* outputs in the grant cycle.
REQ-022 When m_* is idle, m_store, m_width, m_unsigned, m_wdata and m_addr shall all be 0; m_store shall be 1 only in a cycle where d_gnt=1 and d_store=1.
REQ-023 Arbitration: d_req has priority over if_req, unless starve_cnt equals STARVE_MAX, in which case if_req wins.
REQ-024 starve_cnt shall increment, saturating at STARVE_MAX, each cycle if_req=1 and if_gnt=0, and shall clear on if_gnt or when if_req=0.
REQ-025 if_gnt and d_gnt shall never both be 1; neither shall be 1 unless its req is 1.
REQ-026 Requesters shall hold req and payload stable until gnt; the block is not required to tolerate changes before gnt.
REQ-027 Response FSM states: RESP_NONE, RESP_IF, RESP_D; next state = RESP_IF on if_gnt, RESP_D on d_gnt with a load, else RESP_NONE.
REQ-028 In RESP_IF: if_rvalid=1 and if_rdata=m_rdata; in RESP_D: d_rvalid=1 and d_rdata=m_rdata; otherwise rvalid=0 and rdata=0.
REQ-029 Read latency shall be exactly 1 cycle from gnt to rvalid; back-to-back grants on consecutive cycles shall be supported with no bubble.
REQ-030 Stores shall produce no rvalid; store completion is implied by d_gnt.
REQ-031 m_pc shall be if_addr for a fetch grant and the last fetched address register for a data grant.

Reset
REQ-032 While rst=1: if_gnt, d_gnt, if_rvalid and d_rvalid shall be 0, FSM = RESP_NONE, starve_cnt = 0, and the last-fetch register = 0.
REQ-033 A response outstanding when rst asserts shall be dropped; no rvalid shall follow reset.

Structure
REQ-034 The width codes and the FSM state enum shall live in the shared define package next to the existing MEM_BYTE/MEM_HALF/MEM_WORD codes.
REQ-035 One sub-module, arb_starve_ctr, shall hold the saturating starvation counter; everything else shall be flat.

Verification
REQ-036 Fetch only, if_addr=0x100, m_rdata=0xDEADBEEF: if_gnt in cycle 0, if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 1.
REQ-037 Both ports request a load in the same cycle, starve_cnt=0: d_gnt first, if_gnt the next cycle, with d_rvalid then if_rvalid on consecutive cycles.
REQ-038 d_req held high continuously with if_req high, STARVE_MAX=4: if_gnt in cycle 4, then d_gnt resumes.
REQ-039 Store d_addr=0x8, d_wdata=0x55: d_gnt=1 and m_store=1 for one cycle, no d_rvalid; following cycle m_store=0.
REQ-040 rst asserted in the cycle after a load grant: d_rvalid stays 0, all outputs are at reset values, and the first grant after deassert is served normally.
